alu_arbiter: RTL and testbench

Sequential front end that shares the team's combinational 8-bit ALU (`ALU_8bit_flags`) between two independent requesters. It accepts one operation at a time through per-requester valid/ready ports and arbitrates round-robin (or fixed priority). It drives the captured operands into the ALU and returns the registered result and flags, tagged with the requester id, on a single valid/ready response port. It sits between the two issuing units and the shared ALU instance.

---
 rtl/alu_arbiter.sv | 170 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Shares one combinational 8-bit flag ALU between two valid/ready requesters.
// One operation in flight: IDLE grants, EXEC computes, RESP holds the tagged result.

module ALU_8bit_flags (
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   input  logic [2:0] i_op,
   output logic [7:0] o_result,
   output logic       o_carry,
   output logic       o_zero,
   output logic       o_negative,
   output logic       o_overflow
);
   logic [8:0] w_ext;

   always_comb begin
      w_ext      = 9'd0;
      o_result   = 8'd0;
      o_carry    = 1'b0;
      o_overflow = 1'b0;
      case (i_op)
         3'b000: begin
            w_ext      = {1'b0, i_a} + {1'b0, i_b};
            o_result   = w_ext[7:0];
            o_carry    = w_ext[8];
            o_overflow = (i_a[7] == i_b[7]) && (w_ext[7] != i_a[7]);
         end
         3'b001: begin
            // bit 8 of the 9-bit difference is the borrow
            w_ext      = {1'b0, i_a} - {1'b0, i_b};
            o_result   = w_ext[7:0];
            o_carry    = w_ext[8];
            o_overflow = (i_a[7] != i_b[7]) && (w_ext[7] != i_a[7]);
         end
         3'b010:  o_result = i_a & i_b;
         3'b011:  o_result = i_a | i_b;
         3'b100:  o_result = i_a ^ i_b;
         3'b101:  o_result = ~i_a;
         3'b110:  o_result = {i_a[6:0], 1'b0};
         default: o_result = {1'b0, i_a[7:1]};
      endcase
      o_zero     = (o_result == 8'd0);
      o_negative = o_result[7];
   end
endmodule

module alu_arbiter #(
   parameter bit RR_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [7:0] req0_a,
   input  logic [7:0] req0_b,
   input  logic [2:0] req0_op,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [7:0] req1_a,
   input  logic [7:0] req1_b,
   input  logic [2:0] req1_op,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic [7:0] rsp_result,
   output logic       rsp_carry,
   output logic       rsp_zero,
   output logic       rsp_negative,
   output logic       rsp_overflow,
   output logic       busy
);
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
   } req_t;

   state_t       r_state, w_state_nxt;
   req_t         r_opnd;
   req_t [1:0]   w_req;
   logic [1:0]   w_valid;
   logic         w_grant, w_grant_id;
   logic         r_id, r_ptr, r_busy;
   logic         r_rsp_valid, r_rsp_id;
   logic [7:0]   r_rsp_result;
   logic         r_rsp_c, r_rsp_z, r_rsp_n, r_rsp_v;
   logic [7:0]   w_alu_res;
   logic         w_alu_c, w_alu_z, w_alu_n, w_alu_v;

   assign w_req[0] = '{a: req0_a, b: req0_b, op: req0_op};
   assign w_req[1] = '{a: req1_a, b: req1_b, op: req1_op};
   assign w_valid  = {req1_valid, req0_valid};

   // Contention resolves by pointer (RR) or to requester 0; a lone valid always wins.
   always_comb begin
      if (&w_valid) w_grant_id = RR_EN ? r_ptr : 1'b0;
      else          w_grant_id = w_valid[1];
   end

   assign w_grant    = (r_state == S_IDLE) && (|w_valid);
   assign req0_ready = w_grant && !w_grant_id;
   assign req1_ready = w_grant &&  w_grant_id;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (|w_valid) w_state_nxt = S_EXEC;
         S_EXEC:  w_state_nxt = S_RESP;
         S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   ALU_8bit_flags u_alu (
      .i_a        (r_opnd.a),
      .i_b        (r_opnd.b),
      .i_op       (r_opnd.op),
      .o_result   (w_alu_res),
      .o_carry    (w_alu_c),
      .o_zero     (w_alu_z),
      .o_negative (w_alu_n),
      .o_overflow (w_alu_v)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_opnd       <= '0;
         r_id         <= 1'b0;
         r_ptr        <= 1'b0;
         r_busy       <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= 1'b0;
         r_rsp_result <= 8'd0;
         r_rsp_c      <= 1'b0;
         r_rsp_z      <= 1'b0;
         r_rsp_n      <= 1'b0;
         r_rsp_v      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         if (w_grant) begin
            r_opnd <= w_req[w_grant_id];
            r_id   <= w_grant_id;
            r_ptr  <= ~w_grant_id;
         end
         if (r_state == S_EXEC) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= r_id;
            r_rsp_result <= w_alu_res;
            r_rsp_c      <= w_alu_c;
            r_rsp_z      <= w_alu_z;
            r_rsp_n      <= w_alu_n;
            r_rsp_v      <= w_alu_v;
         end else if ((r_state == S_RESP) && rsp_ready) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   assign rsp_valid    = r_rsp_valid;
   assign rsp_id       = r_rsp_id;
   assign rsp_result   = r_rsp_result;
   assign rsp_carry    = r_rsp_c;
   assign rsp_zero     = r_rsp_z;
   assign rsp_negative = r_rsp_n;
   assign rsp_overflow = r_rsp_v;
   assign busy         = r_busy;
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter: RR instance under mixed traffic,
// plus a fixed-priority instance under constant contention.

module tb_alu_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       v0 = 0, v1 = 0, rdy0, rdy1, rsp_ready = 1;
   logic [7:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
   logic [2:0] op0 = 0, op1 = 0;
   logic       rsp_valid, rsp_id, rc, rz, rn, rv, busy;
   logic [7:0] rsp_result;

   logic       fv0 = 0, fv1 = 0, frdy0, frdy1;
   logic [7:0] fa0 = 8'h12, fb0 = 8'h34, fa1 = 8'h90, fb1 = 8'h0F;
   logic [2:0] fop0 = 3'b000, fop1 = 3'b001;
   logic       f_rsp_valid, f_rsp_id, frc, frz, frn, frv, fbusy;
   logic [7:0] f_rsp_result;

   alu_arbiter #(.RR_EN(1'b1)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req0_ready(rdy0), .req0_a(a0), .req0_b(b0), .req0_op(op0),
      .req1_valid(v1), .req1_ready(rdy1), .req1_a(a1), .req1_b(b1), .req1_op(op1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_carry(rc), .rsp_zero(rz), .rsp_negative(rn), .rsp_overflow(rv), .busy(busy));

   alu_arbiter #(.RR_EN(1'b0)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(fv0), .req0_ready(frdy0), .req0_a(fa0), .req0_b(fb0), .req0_op(fop0),
      .req1_valid(fv1), .req1_ready(frdy1), .req1_a(fa1), .req1_b(fb1), .req1_op(fop1),
      .rsp_valid(f_rsp_valid), .rsp_ready(1'b1), .rsp_id(f_rsp_id), .rsp_result(f_rsp_result),
      .rsp_carry(frc), .rsp_zero(frz), .rsp_negative(frn), .rsp_overflow(frv), .busy(fbusy));

   typedef struct { logic [7:0] a; logic [7:0] b; logic [2:0] op; } op_t;
   typedef struct { logic id; logic [7:0] res; logic c, z, n, v; int cyc; } exp_t;

   op_t  rq0[$], rq1[$];
   exp_t sb[$], fsb[$];
   int   grant_log[$], f_log[$];
   int   n_chk = 0, n_fail = 0, cyc = 0, mode = 0, bp_cnt = 0, rsp_cycles = 0;
   int   fcnt0 = 0, fcnt1 = 0;
   bit   ptr = 0, pop0 = 0, pop1 = 0, rand_v = 0, was_valid = 0, prev_hs = 0;
   logic [7:0] last_res;
   logic [3:0] last_flags;

   // Reference ALU from integer arithmetic: carry/overflow as range checks.
   function automatic exp_t ref_alu(input op_t o, input logic id);
      exp_t e;
      int ua = o.a, ub = o.b, sa = $signed(o.a), sbv = $signed(o.b), r = 0, s = 0;
      e.c = 0; e.v = 0; e.id = id; e.cyc = 0;
      case (o.op)
         3'd0: begin r = ua + ub; s = sa + sbv; e.c = (r > 255); e.v = (s > 127 || s < -128); end
         3'd1: begin r = ua - ub; s = sa - sbv; e.c = (r < 0);   e.v = (s > 127 || s < -128); end
         3'd2: r = ua & ub;
         3'd3: r = ua | ub;
         3'd4: r = ua ^ ub;
         3'd5: r = 255 - ua;
         3'd6: r = ua * 2;
         default: r = ua / 2;
      endcase
      e.res = r[7:0];
      e.z = (e.res == 8'd0);
      e.n = e.res[7];
      return e;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic op_t rand_op();
      op_t o;
      o.a = 8'($urandom); o.b = 8'($urandom); o.op = 3'($urandom);
      return o;
   endfunction

   // Driver: updates inputs just after each rising edge.
   always begin
      @(posedge clk);
      cyc++;
      #1;
      if (pop0) begin void'(rq0.pop_front()); pop0 = 0; v0 = 0; end
      if (pop1) begin void'(rq1.pop_front()); pop1 = 0; v1 = 0; end
      if (!v0) v0 = (rq0.size() > 0) && (!rand_v || $urandom_range(0, 2) != 0);
      if (!v1) v1 = (rq1.size() > 0) && (!rand_v || $urandom_range(0, 2) != 0);
      if (v0) begin a0 = rq0[0].a; b0 = rq0[0].b; op0 = rq0[0].op; end
      if (v1) begin a1 = rq1[0].a; b1 = rq1[0].b; op1 = rq1[0].op; end
      bp_cnt = rsp_valid ? bp_cnt + 1 : 0;
      case (mode)
         1:       rsp_ready = 1'($urandom_range(0, 1));
         2:       rsp_ready = (bp_cnt > 5);
         default: rsp_ready = 1'b1;
      endcase
      if (fcnt0 >= 4) fv0 = 0;
      if (fcnt1 >= 4) fv1 = 0;
   end

   // Accept side: grant model and expected-response push.
   always @(negedge clk) if (rst_n) begin
      exp_t e;
      logic id;
      check("one_ready", 32'(rdy0 & rdy1), 0);
      if (rdy0 | rdy1) check("ready_only_idle", 32'(busy | rsp_valid), 0);
      if (rdy0 && !v0) check("ready_without_valid0", 32'(rdy0), 0);
      if (rdy1 && !v1) check("ready_without_valid1", 32'(rdy1), 0);
      if ((v0 | v1) && !busy) check("grant_when_idle", 32'(rdy0 | rdy1), 1);
      if ((v0 && rdy0) || (v1 && rdy1)) begin
         id = rdy1;
         if (v0 && v1) check("rr_winner", 32'(id), 32'(ptr));
         ptr = !id;
         e = ref_alu(id ? rq1[0] : rq0[0], id);
         e.cyc = cyc;
         sb.push_back(e);
         grant_log.push_back(int'(id));
         if (id) pop1 = 1; else pop0 = 1;
      end
   end

   // Monitor: compares every presented response cycle against the scoreboard head.
   always @(negedge clk) if (rst_n) begin
      exp_t e;
      if (prev_hs) check("valid_clears_after_hs", 32'({rsp_valid, busy}), 0);
      if (rsp_valid) begin
         rsp_cycles++;
         check("busy_in_resp", 32'(busy), 1);
         if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_rsp: got id %0d result %0h expected no response", rsp_id, rsp_result);
         end else begin
            e = sb[0];
            if (!was_valid) check("latency", 32'(cyc - e.cyc), 2);
            check("rsp_id", 32'(rsp_id), 32'(e.id));
            check("rsp_result", 32'(rsp_result), 32'(e.res));
            check("rsp_flags", 32'({rc, rz, rn, rv}), 32'({e.c, e.z, e.n, e.v}));
            last_res = rsp_result;
            last_flags = {rc, rz, rn, rv};
            if (rsp_ready) void'(sb.pop_front());
         end
      end
      was_valid = rsp_valid && !rsp_ready;
      prev_hs   = rsp_valid && rsp_ready;
   end

   // Fixed-priority instance: accepts and responses.
   always @(negedge clk) if (rst_n) begin
      exp_t e;
      op_t  o;
      check("fp_one_ready", 32'(frdy0 & frdy1), 0);
      if ((fv0 && frdy0) || (fv1 && frdy1)) begin
         f_log.push_back(int'(frdy1));
         if (frdy1) begin o = '{a: fa1, b: fb1, op: fop1}; fcnt1++; end
         else       begin o = '{a: fa0, b: fb0, op: fop0}; fcnt0++; end
         fsb.push_back(ref_alu(o, frdy1));
      end
      if (f_rsp_valid) begin
         if (fsb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL fp_unexpected_rsp: got id %0d expected no response", f_rsp_id);
         end else begin
            e = fsb.pop_front();
            check("fp_rsp_id", 32'(f_rsp_id), 32'(e.id));
            check("fp_rsp_result", 32'({f_rsp_result, frc, frz, frn, frv}),
                  32'({e.res, e.c, e.z, e.n, e.v}));
         end
      end
   end

   task automatic wait_idle(input string nm, input int budget);
      int t = 0;
      do begin
         @(negedge clk); #1;
         t++;
      end while (!(rq0.size() == 0 && rq1.size() == 0 && sb.size() == 0 && !rsp_valid && !busy)
                 && t < budget);
      if (t >= budget) begin
         n_chk++; n_fail++;
         $display("FAIL %s_timeout: got still busy after %0d cycles expected idle", nm, budget);
      end
   endtask

   initial begin
      int t;
      op_t o;
      repeat (3) @(posedge clk);
      #2 rst_n = 1;
      @(negedge clk);
      check("reset_rsp", 32'({rsp_valid, busy, rsp_id, rsp_result, rc, rz, rn, rv}), 0);
      check("reset_ready", 32'({rdy0, rdy1}), 0);
      check("reset_fp_rsp", 32'({f_rsp_valid, fbusy, f_rsp_id, f_rsp_result}), 0);

      // Both held valid from reset: alternate grants.
      fv0 = 1; fv1 = 1;
      grant_log.delete();
      for (int i = 0; i < 4; i++) begin rq0.push_back(rand_op()); rq1.push_back(rand_op()); end
      wait_idle("rr_both", 300);
      check("rr_grant_count", 32'(grant_log.size()), 8);
      for (int i = 0; i < 8 && i < grant_log.size(); i++)
         check("rr_grant_order", 32'(grant_log[i]), 32'(i % 2));

      rq0.push_back('{a: 8'h7F, b: 8'h01, op: 3'd0});
      wait_idle("add_7f", 50);
      check("add_7f_result", 32'(last_res), 32'h80);
      check("add_7f_flags", 32'(last_flags), 32'b0011);
      rq1.push_back('{a: 8'hFF, b: 8'h01, op: 3'd0});
      wait_idle("add_ff", 50);
      check("add_ff_result", 32'(last_res), 32'h00);
      check("add_ff_flags", 32'(last_flags), 32'b1100);
      rq1.push_back('{a: 8'h00, b: 8'h01, op: 3'd1});
      wait_idle("sub_borrow", 50);
      check("sub_borrow_result", 32'(last_res), 32'hFF);
      check("sub_borrow_flags", 32'(last_flags), 32'b1010);

      // Backpressure: five cycles of rsp_ready=0 after rsp_valid.
      mode = 2;
      rsp_cycles = 0;
      rq0.push_back('{a: 8'hF0, b: 8'h3C, op: 3'd2});
      rq1.push_back('{a: 8'h11, b: 8'h22, op: 3'd4});
      wait_idle("backpressure", 100);
      check("bp_valid_cycles", 32'(rsp_cycles), 12);
      mode = 0;

      // Random traffic with sporadic valids and random consumer backpressure.
      mode = 1; rand_v = 1;
      for (int i = 0; i < 40; i++) begin
         o = rand_op();
         if ($urandom_range(0, 1) != 0) rq1.push_back(o); else rq0.push_back(o);
      end
      wait_idle("random", 3000);
      mode = 0; rand_v = 0;

      // Reset during EXEC: response dropped, pointer back to requester 0.
      rq0.push_back('{a: 8'h05, b: 8'h06, op: 3'd0});
      t = 0;
      do begin @(negedge clk); #1; t++; end while (sb.size() == 0 && t < 50);
      check("rst_test_accept", 32'(sb.size()), 1);
      @(posedge clk); #2;
      rst_n = 0;
      sb.delete();
      @(posedge clk); #2;
      rst_n = 1;
      ptr = 0;
      @(negedge clk);
      check("abort_outputs", 32'({rsp_valid, busy, rsp_id, rsp_result, rc, rz, rn, rv, rdy0, rdy1}), 0);
      repeat (4) begin
         @(negedge clk);
         check("abort_no_valid", 32'(rsp_valid), 0);
      end
      grant_log.delete();
      rq0.push_back(rand_op());
      rq1.push_back(rand_op());
      wait_idle("post_reset", 50);
      check("post_reset_first_grant", 32'(grant_log.size() > 0 ? grant_log[0] : 9), 0);

      // Fixed-priority instance was restarted by the same reset; let it finish.
      t = 0;
      while (!(fcnt0 >= 4 && fcnt1 >= 4 && fsb.size() == 0 && !fbusy) && t < 200) begin
         @(negedge clk); #1; t++;
      end
      check("fp_done", 32'(t < 200), 1);
      for (int i = 0; i < 8 && i < f_log.size(); i++)
         check("fp_grant_order", 32'(f_log[f_log.size() - 8 + i]), 32'(i >= 4));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
